morse_main_prueba: RTL and testbench
====================================

Name: morse_main_prueba

Overview:
- Single-character Morse code transmitter. Accepts a 7-bit ASCII code on RxData and, on a Start pulse, keys the Morse pattern of that character onto the serial on/off output Y.
- Sits between the character source (UART receiver or switches) and the keying output (LED or buzzer driver).
- One character per Start. The host reloads RxData between characters.

Parameters:
- DOT_CYCLES, 25_000_000, clock cycles per Morse time unit (0.25 s at 100 MHz). Benches override it to a small value, e.g. 2. Legal range 1 to 2^32-1.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-low reset
- RxData  input  7  ASCII character to send; sampled only when Start is accepted
- Start  input  1  request to transmit; level-sampled on rising CLK edges
- Y  output  1  Morse keying output, registered; 1 = tone/mark, 0 = silence

Behaviour:
- Interface: one clock (CLK). Reset RST is asynchronous and active-low.
- Reset: state goes to IDLE, Y=0, counters and latched character cleared. Reset asserted mid-transmission aborts immediately. Y drops to 0 asynchronously.
- Start acceptance: only in IDLE. A Start seen on an edge in IDLE latches RxData on that same edge. Start in any other state is ignored; there is no queueing.
- Start held high for several cycles triggers exactly one transmission. Re-triggering requires IDLE plus Start still high, so a Start held continuously resends after completion.
- Character table, each pattern MSB-first, bit 1 = dash, bit 0 = dot, length 1..5:
  - 'A'..'Z' (65..90): ITU patterns.
  - 'a'..'z' (97..122): mapped to the uppercase codes.
  - '0'..'9' (48..57): ITU 5-element patterns.
  - Space (32): word gap only.
  - Any other code: unsupported. Accepted but produces no marks; Y stays 0 and the block returns to IDLE on the next edge.
- Timing in units U = DOT_CYCLES cycles:
  - dot = Y high 1U; dash = Y high 3U.
  - Intra-character gap = Y low 1U.
  - After the last element, a letter gap of Y low 3U, then IDLE.
  - Space: Y low 7U, then IDLE.
- Latency: Y rises on the same edge that accepts Start (first mark begins there).
- FSM states:
  - IDLE: on Start, go to MARK if the character is valid, to WORDGAP if it is a space, else stay in IDLE.
  - MARK: counts 1U or 3U with Y=1. Goes to GAP if elements remain, else to LETTERGAP.
  - GAP: counts 1U with Y=0, then MARK for the next element.
  - LETTERGAP: counts 3U, then IDLE.
  - WORDGAP: counts 7U, then IDLE.
- Counting:
  - Cycle counter: 32-bit, reloads at each state entry.
  - Element index: 3-bit, counts down from length-1.
  - Y is driven from a register, glitch-free.

Decomposition:
- Shared package morse_pkg holds:
  - state enum (IDLE, MARK, GAP, LETTERGAP, WORDGAP);
  - unit multipliers DOT_U=1, DASH_U=3, GAP_U=1, LETTER_U=3, WORD_U=7;
  - ASCII constants for space and for the range bounds.
- Sub-module morse_rom: combinational ASCII[6:0] -> {valid, is_space, len[2:0], pattern[4:0]}.
- FSM, counters and Y register live in the top level.

Test Plan (DOT_CYCLES=2, 10 ns clock):
- Reset, then RxData stepped 'A'..'K' every 20 ns, then a one-cycle Start with 'K' (75) -> Y: high 6, low 2, high 2, low 2, high 6, low 6 cycles, then IDLE with Y=0. The stepping before Start produces no output.
- 'E' (69) with Start -> Y high 2 cycles, low 6, idle. '0' (48) -> five marks of 6 cycles each, separated by 2-cycle gaps.
- Start held 3 cycles with 'T' (84) -> exactly one dash of 6 cycles. Start pulses during the transmission have no effect.
- '#' (35) or DEL (127) with Start -> Y stays 0 throughout; the next Start with 'E' one cycle later is accepted.
- Space (32) with Start -> Y=0 for 14 cycles. A Start pulse during that window is ignored; a Start after the window is accepted.
- RST low in the middle of a 'Q' dash -> Y=0 immediately, no clock needed. After release, Start with 'E' transmits normally.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM states, unit multipliers and ASCII bounds for the Morse transmitter
package morse_pkg;
   typedef enum logic [2:0] {IDLE, MARK, GAP, LETTERGAP, WORDGAP} state_e;
   localparam logic [2:0] DOT_U       = 3'd1;
   localparam logic [2:0] DASH_U      = 3'd3;
   localparam logic [2:0] GAP_U       = 3'd1;
   localparam logic [2:0] LETTER_U    = 3'd3;
   localparam logic [2:0] WORD_U      = 3'd7;
   localparam logic [6:0] ASCII_SPACE = 7'd32;
   localparam logic [6:0] ASCII_0     = 7'd48;
   localparam logic [6:0] ASCII_9     = 7'd57;
   localparam logic [6:0] ASCII_UA    = 7'd65;
   localparam logic [6:0] ASCII_UZ    = 7'd90;
   localparam logic [6:0] ASCII_LA    = 7'd97;
   localparam logic [6:0] ASCII_LZ    = 7'd122;
endpackage

// File: rtl/morse_rom.sv
// morse_rom: ASCII code to Morse pattern lookup, pattern right-aligned with first element at bit len-1
module morse_rom
   import morse_pkg::*;
(
   input  logic [6:0] ascii_i,
   output logic       valid_o,
   output logic       is_space_o,
   output logic [2:0] len_o,
   output logic [4:0] pat_o
);
   logic [6:0] up;
   logic [6:0] li;
   logic [6:0] di;
   logic       is_let;
   logic       is_dig;
   logic [7:0] let_lp;
   logic [4:0] dig_p;
   // Fold lowercase onto uppercase and classify the code
   always_comb begin
      up     = (ascii_i >= ASCII_LA && ascii_i <= ASCII_LZ) ? ascii_i - 7'd32 : ascii_i;
      is_let = up >= ASCII_UA && up <= ASCII_UZ;
      is_dig = ascii_i >= ASCII_0 && ascii_i <= ASCII_9;
      li     = up - ASCII_UA;
      di     = ascii_i - ASCII_0;
   end
   // Letter table as {len, pattern}
   always_comb begin
      case (li)
         7'd0:    let_lp = {3'd2, 5'b00001};
         7'd1:    let_lp = {3'd4, 5'b01000};
         7'd2:    let_lp = {3'd4, 5'b01010};
         7'd3:    let_lp = {3'd3, 5'b00100};
         7'd4:    let_lp = {3'd1, 5'b00000};
         7'd5:    let_lp = {3'd4, 5'b00010};
         7'd6:    let_lp = {3'd3, 5'b00110};
         7'd7:    let_lp = {3'd4, 5'b00000};
         7'd8:    let_lp = {3'd2, 5'b00000};
         7'd9:    let_lp = {3'd4, 5'b00111};
         7'd10:   let_lp = {3'd3, 5'b00101};
         7'd11:   let_lp = {3'd4, 5'b00100};
         7'd12:   let_lp = {3'd2, 5'b00011};
         7'd13:   let_lp = {3'd2, 5'b00010};
         7'd14:   let_lp = {3'd3, 5'b00111};
         7'd15:   let_lp = {3'd4, 5'b00110};
         7'd16:   let_lp = {3'd4, 5'b01101};
         7'd17:   let_lp = {3'd3, 5'b00010};
         7'd18:   let_lp = {3'd3, 5'b00000};
         7'd19:   let_lp = {3'd1, 5'b00001};
         7'd20:   let_lp = {3'd3, 5'b00001};
         7'd21:   let_lp = {3'd4, 5'b00001};
         7'd22:   let_lp = {3'd3, 5'b00011};
         7'd23:   let_lp = {3'd4, 5'b01001};
         7'd24:   let_lp = {3'd4, 5'b01011};
         7'd25:   let_lp = {3'd4, 5'b01100};
         default: let_lp = 8'd0;
      endcase
   end
   // Digit table, all five elements long
   always_comb begin
      case (di)
         7'd0:    dig_p = 5'b11111;
         7'd1:    dig_p = 5'b01111;
         7'd2:    dig_p = 5'b00111;
         7'd3:    dig_p = 5'b00011;
         7'd4:    dig_p = 5'b00001;
         7'd5:    dig_p = 5'b00000;
         7'd6:    dig_p = 5'b10000;
         7'd7:    dig_p = 5'b11000;
         7'd8:    dig_p = 5'b11100;
         default: dig_p = 5'b11110;
      endcase
   end
   // Select the entry; anything outside the table yields length 0
   always_comb begin
      {len_o, pat_o} = is_let ? let_lp : is_dig ? {3'd5, dig_p} : 8'd0;
      valid_o        = is_let || is_dig;
      is_space_o     = ascii_i == ASCII_SPACE;
   end
endmodule

// File: rtl/morse_main_prueba.sv
// morse_main_prueba: keys one ASCII character per Start as Morse marks on Y
module morse_main_prueba
   import morse_pkg::*;
#(
   parameter int unsigned DOT_CYCLES = 25_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] RxData,
   input  logic       Start,
   output logic       Y
);
   localparam logic [31:0] CYC_RELOAD = DOT_CYCLES - 32'd1;
   state_e      state_q, state_d;
   logic [31:0] cyc_q, cyc_d;
   logic [2:0]  unit_q, unit_d;
   logic [2:0]  idx_q, idx_d;
   logic [4:0]  pat_q, pat_d;
   logic        y_q;
   logic        rom_valid;
   logic        rom_space;
   logic [2:0]  rom_len;
   logic [4:0]  rom_pat;
   morse_rom u_rom (
      .ascii_i    (RxData),
      .valid_o    (rom_valid),
      .is_space_o (rom_space),
      .len_o      (rom_len),
      .pat_o      (rom_pat)
   );
   // Next state: accept in IDLE, otherwise count cycles within units, then units within the state
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      unit_d  = unit_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      if (state_q == IDLE) begin
         if (Start) begin
            pat_d   = rom_pat;
            idx_d   = rom_len - 3'd1;
            cyc_d   = CYC_RELOAD;
            unit_d  = rom_space ? WORD_U - 3'd1 : rom_pat[rom_len - 3'd1] ? DASH_U - 3'd1 : DOT_U - 3'd1;
            state_d = rom_valid ? MARK : rom_space ? WORDGAP : IDLE;
         end
      end else if (cyc_q != 32'd0) begin
         cyc_d = cyc_q - 32'd1;
      end else if (unit_q != 3'd0) begin
         cyc_d  = CYC_RELOAD;
         unit_d = unit_q - 3'd1;
      end else begin
         cyc_d   = CYC_RELOAD;
         state_d = state_q == MARK ? (idx_q != 3'd0 ? GAP : LETTERGAP) : state_q == GAP ? MARK : IDLE;
         idx_d   = (state_q == MARK && idx_q != 3'd0) ? idx_q - 3'd1 : idx_q;
         unit_d  = state_d == GAP ? GAP_U - 3'd1 :
                   state_d == LETTERGAP ? LETTER_U - 3'd1 :
                   state_d == MARK ? (pat_q[idx_q] ? DASH_U - 3'd1 : DOT_U - 3'd1) : 3'd0;
      end
   end
   // State, counters, latched pattern and the registered keying output
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cyc_q   <= 32'd0;
         unit_q  <= 3'd0;
         idx_q   <= 3'd0;
         pat_q   <= 5'd0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         unit_q  <= unit_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         y_q     <= state_d == MARK;
      end
   end
   assign Y = y_q;
endmodule

// File: tb/tb_morse_main_prueba.sv
// tb_morse_main_prueba: randomized and directed Morse stimulus checked cycle by cycle against a waveform model
module tb_morse_main_prueba;
   localparam int DC = 2;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [6:0] RxData = 7'd0;
   logic       Start = 1'b0;
   logic       Y;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit wave[$];
   bit sb[$];
   string letters[26] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",".---","-.-",".-..","--",
                          "-.","---",".--.","--.-",".-.","...","-","..-","...-",".--","-..-","-.--","--.."};
   string digits[10] = '{"-----",".----","..---","...--","....-",".....","-....","--...","---..","----."};
   morse_main_prueba #(.DOT_CYCLES(DC)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .RxData (RxData),
      .Start  (Start),
      .Y      (Y)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, got, exp);
      end
   endtask
   // Expected Y after an accepted edge: marks and gaps in units, letter or word gap, then the edge back to idle
   task automatic build(input logic [6:0] c);
      int    code;
      string s;
      bit    sup;
      code = int'(c);
      if (code >= 97 && code <= 122) code -= 32;
      sup = 1'b1;
      if (code >= 65 && code <= 90) s = letters[code-65];
      else if (code >= 48 && code <= 57) s = digits[code-48];
      else if (code == 32) s = "";
      else sup = 1'b0;
      if (!sup) return;
      for (int k = 0; k < s.len(); k++) begin
         repeat ((s[k] == "-" ? 3 : 1) * DC) wave.push_back(1'b1);
         if (k < s.len() - 1) repeat (DC) wave.push_back(1'b0);
      end
      repeat ((code == 32 ? 7 : 3) * DC + 1) wave.push_back(1'b0);
   endtask
   always @(posedge CLK) begin
      cyc++;
      if (!RST) wave.delete();
      else if (wave.size() == 0 && Start) build(RxData);
      if (wave.size() != 0) sb.push_back(wave.pop_front());
      else sb.push_back(1'b0);
   end
   always @(posedge CLK) begin
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty cycle=%0d got=none expected=entry", cyc);
      end else chk("Y", Y, sb.pop_front());
   end
   task automatic idle(input int n);
      Start = 1'b0;
      repeat (n) @(negedge CLK);
   endtask
   task automatic send(input logic [6:0] c, input int hold);
      @(negedge CLK);
      RxData = c;
      Start  = 1'b1;
      repeat (hold) @(negedge CLK);
      Start = 1'b0;
   endtask
   task automatic wait_idle();
      int i;
      for (i = 0; i < 400 && wave.size() != 0; i++) @(negedge CLK);
      chk("idle_timeout", wave.size() == 0, 1'b1);
      @(negedge CLK);
   endtask
   initial begin
      repeat (3) @(negedge CLK);
      chk("reset_Y", Y, 1'b0);
      RST = 1'b1;
      for (int c = 65; c <= 75; c++) begin
         RxData = 7'(c);
         repeat (2) @(negedge CLK);
      end
      send(7'd75, 1);
      wait_idle();
      send(7'd69, 1);
      wait_idle();
      send(7'd48, 1);
      wait_idle();
      send(7'd84, 3);
      idle(1);
      send(7'd69, 1);
      wait_idle();
      @(negedge CLK);
      RxData = 7'd35;
      Start  = 1'b1;
      @(negedge CLK);
      RxData = 7'd69;
      @(negedge CLK);
      Start = 1'b0;
      wait_idle();
      send(7'd127, 1);
      idle(3);
      send(7'd32, 1);
      idle(5);
      send(7'd69, 1);
      wait_idle();
      send(7'd101, 1);
      wait_idle();
      send(7'd69, 20);
      wait_idle();
      send(7'd81, 1);
      @(posedge CLK);
      #3 RST = 1'b0;
      #1 chk("async_reset_Y", Y, 1'b0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      send(7'd69, 1);
      wait_idle();
      for (int n = 0; n < 40; n++) begin
         int       r;
         logic [6:0] c;
         r = $urandom_range(0, 4);
         c = r == 0 ? 7'($urandom_range(65, 90)) : r == 1 ? 7'($urandom_range(97, 122)) :
             r == 2 ? 7'($urandom_range(48, 57)) : r == 3 ? 7'd32 : 7'($urandom_range(0, 127));
         send(c, $urandom_range(1, 3));
         idle($urandom_range(0, 15));
      end
      wait_idle();
      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
